ttt_turn_controller: RTL and testbench

Turn sequencer and move arbiter for the tic-tac-toe game. It owns the single write port into the board register file and decides which requester (player or computer) may use it. It validates each requested square and issues one write strobe per legal move. It then waits for the win checker's verdict and either hands the turn to the other side or ends the game.

---
 rtl/ttt_turn_controller.sv | 127 ++++++++++++
 tb/tb_ttt_turn_controller.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_turn_controller.sv
// Turn sequencer and move arbiter for tic-tac-toe.
// Owns the single board write port. It accepts a rising-edge request from the
// side holding the turn, validates the square, and issues one write strobe per
// legal move. After the write it samples the win checker and either passes the
// turn or ends the game.
//
// Ports:
//   clock              game clock, rising edge
//   reset              synchronous active-high clear
//   play / pc          player / computer move buttons (level; rising edge = request)
//   player_position    requested square for the player, legal 1..9
//   computer_position  requested square for the computer, legal 1..9
//   who                win-checker verdict: 00 none, 01 player, 10 computer
//   wr_en              one-cycle board write strobe
//   wr_pos / wr_who    square and owner code of the last write (hold after wr_en drops)
//   occupied           bit k-1 set when square k is taken
//   turn               side allowed to move: 0 player, 1 computer
//   illegal            one-cycle pulse on a rejected turn-holder request
//   result             00 in progress, 01 player, 10 computer, 11 draw
//   game_over          high once the game has ended
module ttt_turn_controller #(
  parameter bit FIRST_MOVER = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       pc,
  input  logic [3:0] player_position,
  input  logic [3:0] computer_position,
  input  logic [1:0] who,
  output logic       wr_en,
  output logic [3:0] wr_pos,
  output logic [1:0] wr_who,
  output logic [8:0] occupied,
  output logic       turn,
  output logic       illegal,
  output logic [1:0] result,
  output logic       game_over
);

  typedef enum logic [1:0] {StWait, StWrite, StEval, StDone} state_e;

  state_e     state_q;
  logic       play_q;
  logic       pc_q;
  logic [3:0] move_count_q;

  logic       play_edge;
  logic       pc_edge;
  logic       req;
  logic [3:0] req_pos;
  logic [8:0] req_square;
  logic       legal;

  always_comb begin
    play_edge = play & ~play_q;
    pc_edge   = pc & ~pc_q;
    // Only the turn-holder's edge matters; the other side is ignored silently.
    req       = turn ? pc_edge : play_edge;
    req_pos   = turn ? computer_position : player_position;
    // One-hot square select; all zero for out-of-range positions.
    req_square = '0;
    for (int k = 0; k < 9; k++) begin
      req_square[k] = (req_pos == 4'(k + 1));
    end
    legal = (|req_square) && ((req_square & occupied) == 9'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StWait;
      // Loaded high so a button held through reset does not fire on release.
      play_q       <= 1'b1;
      pc_q         <= 1'b1;
      move_count_q <= 4'd0;
      wr_en        <= 1'b0;
      wr_pos       <= 4'd0;
      wr_who       <= 2'b00;
      occupied     <= 9'd0;
      turn         <= FIRST_MOVER;
      illegal      <= 1'b0;
      result       <= 2'b00;
      game_over    <= 1'b0;
    end else begin
      // Edge registers track every cycle so requests outside WAIT are dropped.
      play_q  <= play;
      pc_q    <= pc;
      wr_en   <= 1'b0;
      illegal <= 1'b0;
      case (state_q)
        StWait: begin
          if (req) begin
            if (legal) begin
              wr_en        <= 1'b1;
              wr_pos       <= req_pos;
              wr_who       <= turn ? 2'b10 : 2'b01;
              occupied     <= occupied | req_square;
              move_count_q <= move_count_q + 4'd1;
              state_q      <= StWrite;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        StWrite: state_q <= StEval;
        StEval: begin
          // A win takes priority over a full board; who=11 counts as no winner.
          if (who == 2'b01 || who == 2'b10) begin
            result    <= who;
            game_over <= 1'b1;
            state_q   <= StDone;
          end else if (move_count_q == 4'd9) begin
            result    <= 2'b11;
            game_over <= 1'b1;
            state_q   <= StDone;
          end else begin
            turn    <= ~turn;
            state_q <= StWait;
          end
        end
        StDone: ;
        default: state_q <= StWait;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_turn_controller.sv
module tb_ttt_turn_controller;

  logic       clock;
  logic       reset;
  logic       play;
  logic       pc;
  logic [3:0] player_position;
  logic [3:0] computer_position;
  logic [1:0] who;
  logic       wr_en;
  logic [3:0] wr_pos;
  logic [1:0] wr_who;
  logic [8:0] occupied;
  logic       turn;
  logic       illegal;
  logic [1:0] result;
  logic       game_over;

  int passed = 0;
  int total  = 0;

  ttt_turn_controller #(.FIRST_MOVER(1'b0)) dut (
    .clock             (clock),
    .reset             (reset),
    .play              (play),
    .pc                (pc),
    .player_position   (player_position),
    .computer_position (computer_position),
    .who               (who),
    .wr_en             (wr_en),
    .wr_pos            (wr_pos),
    .wr_who            (wr_who),
    .occupied          (occupied),
    .turn              (turn),
    .illegal           (illegal),
    .result            (result),
    .game_over         (game_over)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observations of one request attempt: cycle N+1, N+2 and N+3.
  typedef struct packed {
    logic       en1;
    logic       ill1;
    logic [3:0] pos1;
    logic [1:0] who1;
    logic [8:0] occ1;
    logic       en2;
    logic       ill2;
    logic       turn3;
    logic [1:0] res3;
    logic       over3;
  } snap_t;

  // Reference model: board as an owner array, game rules applied directly.
  int         m_owner[16];
  bit         m_turn;
  int         m_moves;
  logic [1:0] m_result;
  bit         m_over;
  logic [3:0] m_last_pos;
  logic [1:0] m_last_who;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    play  = 1'b0;
    pc    = 1'b0;
    who   = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) m_owner[k] = 0;
    m_turn     = 1'b0;
    m_moves    = 0;
    m_result   = 2'b00;
    m_over     = 1'b0;
    m_last_pos = 4'd0;
    m_last_who = 2'b00;
  endtask

  task automatic model_attempt(input logic p, input logic c, input logic [3:0] pp,
                               input logic [3:0] cp, input logic [1:0] wv, output snap_t e);
    logic       side_req;
    logic [3:0] pos;
    e = '0;
    if (!m_over) begin
      side_req = m_turn ? c : p;
      pos      = m_turn ? cp : pp;
      if (side_req) begin
        if (pos >= 1 && pos <= 9 && m_owner[pos] == 0) begin
          m_owner[pos] = m_turn ? 2 : 1;
          m_moves++;
          m_last_pos = pos;
          m_last_who = m_turn ? 2'b10 : 2'b01;
          e.en1      = 1'b1;
          if (wv == 2'b01 || wv == 2'b10) begin
            m_result = wv;
            m_over   = 1'b1;
          end else if (m_moves == 9) begin
            m_result = 2'b11;
            m_over   = 1'b1;
          end else begin
            m_turn = ~m_turn;
          end
        end else begin
          e.ill1 = 1'b1;
        end
      end
    end
    e.pos1 = m_last_pos;
    e.who1 = m_last_who;
    for (int k = 1; k <= 9; k++) e.occ1[k-1] = (m_owner[k] != 0);
    e.turn3 = m_turn;
    e.res3  = m_result;
    e.over3 = m_over;
  endtask

  // Drives one request attempt over three cycles and records what was seen.
  task automatic attempt(input logic p, input logic c, input logic [3:0] pp,
                         input logic [3:0] cp, input logic [1:0] wv, output snap_t s);
    player_position   = pp;
    computer_position = cp;
    who  = wv;
    play = p;
    pc   = c;
    step();
    s.en1  = wr_en;
    s.ill1 = illegal;
    s.pos1 = wr_pos;
    s.who1 = wr_who;
    s.occ1 = occupied;
    play = 1'b0;
    pc   = 1'b0;
    step();
    s.en2  = wr_en;
    s.ill2 = illegal;
    step();
    s.turn3 = turn;
    s.res3  = result;
    s.over3 = game_over;
    who = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({wr_en, wr_pos, wr_who, illegal} !== 8'd0)
      $display("FAIL reset_write got en=%b pos=%0d who=%b ill=%b want 0", wr_en, wr_pos,
               wr_who, illegal);
    else passed++;
    total++;
    if (occupied !== 9'd0) $display("FAIL reset_occupied got %h want 000", occupied);
    else passed++;
    total++;
    if ({turn, result, game_over} !== 4'd0)
      $display("FAIL reset_status got turn=%b res=%b over=%b want 0", turn, result, game_over);
    else passed++;
  endtask

  task automatic test_first_move();
    snap_t s;
    do_reset();
    attempt(1'b1, 1'b0, 4'd5, 4'd0, 2'b00, s);
    total++;
    if ({s.en1, s.pos1, s.who1} !== {1'b1, 4'd5, 2'b01})
      $display("FAIL first_write got en=%b pos=%0d who=%b want 1 5 01", s.en1, s.pos1, s.who1);
    else passed++;
    total++;
    if (s.occ1 !== 9'h010) $display("FAIL first_occupied got %h want 010", s.occ1);
    else passed++;
    total++;
    if (s.en2 !== 1'b0) $display("FAIL first_strobe_len got %b want 0", s.en2);
    else passed++;
    total++;
    if (s.turn3 !== 1'b1) $display("FAIL first_turn got %b want 1", s.turn3);
    else passed++;
  endtask

  task automatic test_illegal_occupied();
    snap_t s;
    attempt(1'b0, 1'b1, 4'd0, 4'd5, 2'b00, s);
    total++;
    if ({s.en1, s.ill1, s.ill2} !== 3'b010)
      $display("FAIL occ_illegal got en=%b ill=%b ill_next=%b want 0 1 0", s.en1, s.ill1, s.ill2);
    else passed++;
    total++;
    if ({s.pos1, s.who1, s.turn3} !== {4'd5, 2'b01, 1'b1})
      $display("FAIL occ_hold got pos=%0d who=%b turn=%b want 5 01 1", s.pos1, s.who1, s.turn3);
    else passed++;
    attempt(1'b0, 1'b1, 4'd0, 4'd1, 2'b00, s);
    total++;
    if ({s.en1, s.pos1, s.who1, s.occ1} !== {1'b1, 4'd1, 2'b10, 9'h011})
      $display("FAIL pc_write got en=%b pos=%0d who=%b occ=%h want 1 1 10 011", s.en1, s.pos1,
               s.who1, s.occ1);
    else passed++;
    total++;
    if (s.turn3 !== 1'b0) $display("FAIL pc_turn got %b want 0", s.turn3);
    else passed++;
  endtask

  task automatic test_wrong_side();
    snap_t s;
    // Both buttons rise on the player's turn: only the player's square is written.
    attempt(1'b1, 1'b1, 4'd2, 4'd3, 2'b00, s);
    total++;
    if ({s.en1, s.pos1, s.who1, s.occ1} !== {1'b1, 4'd2, 2'b01, 9'h013})
      $display("FAIL both_edges got en=%b pos=%0d who=%b occ=%h want 1 2 01 013", s.en1, s.pos1,
               s.who1, s.occ1);
    else passed++;
    // Player presses on the computer's turn: silently ignored.
    attempt(1'b1, 1'b0, 4'd7, 4'd0, 2'b00, s);
    total++;
    if ({s.en1, s.ill1, s.occ1, s.turn3} !== {2'b00, 9'h013, 1'b1})
      $display("FAIL wrong_side got en=%b ill=%b occ=%h turn=%b want 0 0 013 1", s.en1, s.ill1,
               s.occ1, s.turn3);
    else passed++;
  endtask

  task automatic test_player_win();
    snap_t s;
    logic [3:0] seq[5] = '{4'd1, 4'd4, 4'd2, 4'd5, 4'd3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) attempt(1'b1, 1'b0, seq[i], 4'd0, (i == 4) ? 2'b01 : 2'b00, s);
      else attempt(1'b0, 1'b1, 4'd0, seq[i], 2'b00, s);
      if (i == 3) begin
        total++;
        if ({s.res3, s.over3} !== 3'b000)
          $display("FAIL win_early got res=%b over=%b want 00 0", s.res3, s.over3);
        else passed++;
      end
    end
    total++;
    if ({s.res3, s.over3} !== 3'b011)
      $display("FAIL win_result got res=%b over=%b want 01 1", s.res3, s.over3);
    else passed++;
    attempt(1'b0, 1'b1, 4'd0, 4'd6, 2'b00, s);
    total++;
    if ({s.en1, s.ill1, s.res3, s.over3} !== 5'b00011)
      $display("FAIL done_pc got en=%b ill=%b res=%b over=%b want 0 0 01 1", s.en1, s.ill1,
               s.res3, s.over3);
    else passed++;
    attempt(1'b1, 1'b0, 4'd7, 4'd0, 2'b00, s);
    total++;
    if ({s.en1, s.ill1, s.occ1} !== {2'b00, 9'h01F})
      $display("FAIL done_play got en=%b ill=%b occ=%h want 0 0 01f", s.en1, s.ill1, s.occ1);
    else passed++;
  endtask

  task automatic test_draw();
    snap_t s;
    logic [3:0] seq[9] = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd6, 4'd8, 4'd7, 4'd9};
    do_reset();
    attempt(1'b1, 1'b0, 4'd0, 4'd0, 2'b00, s);
    total++;
    if ({s.en1, s.ill1, s.turn3} !== 3'b010)
      $display("FAIL pos0_illegal got en=%b ill=%b turn=%b want 0 1 0", s.en1, s.ill1, s.turn3);
    else passed++;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin
        attempt(1'b0, 1'b1, 4'd0, 4'd12, 2'b00, s);
        total++;
        if ({s.en1, s.ill1, s.turn3} !== 3'b011)
          $display("FAIL pos12_illegal got en=%b ill=%b turn=%b want 0 1 1", s.en1, s.ill1,
                   s.turn3);
        else passed++;
      end
      if (i % 2 == 0) attempt(1'b1, 1'b0, seq[i], 4'd0, 2'b00, s);
      else attempt(1'b0, 1'b1, 4'd0, seq[i], 2'b00, s);
      total++;
      if ({s.en1, s.pos1} !== {1'b1, seq[i]})
        $display("FAIL draw_move%0d got en=%b pos=%0d want 1 %0d", i, s.en1, s.pos1, seq[i]);
      else passed++;
      if (i == 7) begin
        total++;
        if (s.over3 !== 1'b0) $display("FAIL draw_early got over=%b want 0", s.over3);
        else passed++;
      end
    end
    total++;
    if ({s.occ1, s.res3, s.over3} !== {9'h1FF, 2'b11, 1'b1})
      $display("FAIL draw_result got occ=%h res=%b over=%b want 1ff 11 1", s.occ1, s.res3,
               s.over3);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    snap_t s;
    do_reset();
    player_position = 4'd5;
    play = 1'b1;
    step();
    total++;
    if (wr_en !== 1'b1) $display("FAIL midwrite_strobe got %b want 1", wr_en);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({wr_en, wr_pos, wr_who, occupied, turn, illegal, result, game_over} !== 21'd0)
      $display("FAIL midwrite_reset got en=%b pos=%0d who=%b occ=%h turn=%b ill=%b res=%b ovr=%b",
               wr_en, wr_pos, wr_who, occupied, turn, illegal, result, game_over);
    else passed++;
    step();
    step();
    total++;
    if ({wr_en, illegal, occupied} !== 11'd0)
      $display("FAIL held_button got en=%b ill=%b occ=%h want 0 0 000", wr_en, illegal, occupied);
    else passed++;
    play = 1'b0;
    step();
    attempt(1'b1, 1'b0, 4'd5, 4'd0, 2'b00, s);
    total++;
    if ({s.en1, s.occ1, s.turn3} !== {1'b1, 9'h010, 1'b1})
      $display("FAIL after_reset got en=%b occ=%h turn=%b want 1 010 1", s.en1, s.occ1, s.turn3);
    else passed++;
  endtask

  task automatic test_random();
    snap_t s;
    snap_t e;
    logic       p;
    logic       c;
    logic [3:0] pp;
    logic [3:0] cp;
    logic [1:0] wv;
    int         r;
    for (int g = 0; g < 25; g++) begin
      do_reset();
      model_reset();
      for (int a = 0; a < 40; a++) begin
        r = $urandom_range(0, 9);
        if (r < 7) begin
          p = ~m_turn;
          c = m_turn;
        end else if (r == 7) begin
          p = m_turn;
          c = ~m_turn;
        end else begin
          p = 1'b1;
          c = 1'b1;
        end
        pp = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(0, 15));
        cp = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(0, 15));
        wv = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        model_attempt(p, c, pp, cp, wv, e);
        attempt(p, c, pp, cp, wv, s);
        total++;
        if ({s.en1, s.ill1, s.en2, s.ill2} !== {e.en1, e.ill1, e.en2, e.ill2})
          $display("FAIL rnd_pulses g%0d a%0d got %b%b%b%b want %b%b%b%b", g, a, s.en1, s.ill1,
                   s.en2, s.ill2, e.en1, e.ill1, e.en2, e.ill2);
        else passed++;
        total++;
        if ({s.pos1, s.who1} !== {e.pos1, e.who1})
          $display("FAIL rnd_wr g%0d a%0d got pos=%0d who=%b want %0d %b", g, a, s.pos1, s.who1,
                   e.pos1, e.who1);
        else passed++;
        total++;
        if (s.occ1 !== e.occ1)
          $display("FAIL rnd_occ g%0d a%0d got %h want %h", g, a, s.occ1, e.occ1);
        else passed++;
        total++;
        if ({s.turn3, s.res3, s.over3} !== {e.turn3, e.res3, e.over3})
          $display("FAIL rnd_status g%0d a%0d got t=%b r=%b o=%b want %b %b %b", g, a, s.turn3,
                   s.res3, s.over3, e.turn3, e.res3, e.over3);
        else passed++;
        if (m_over && a > 2 && $urandom_range(0, 3) == 0) break;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    play  = 1'b0;
    pc    = 1'b0;
    who   = 2'b00;
    player_position   = 4'd0;
    computer_position = 4'd0;
    test_reset();
    test_first_move();
    test_illegal_occupied();
    test_wrong_side();
    test_player_win();
    test_draw();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout got still running want finished");
    $fatal(1, "time limit expired");
  end

endmodule
